// File: rtl/rggen_host_arbiter.sv
// Round-robin arbiter sharing one register-block command/response port between HOSTS bridges.
// The grant is held from command issue until the downstream response pulse.
module rggen_host_arbiter #(
    parameter int unsigned HOSTS         = 2,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [HOSTS-1:0]               i_host_command_valid,
    input  logic [HOSTS-1:0]               i_host_read,
    input  logic [HOSTS*ADDRESS_WIDTH-1:0] i_host_address,
    input  logic [HOSTS*DATA_WIDTH-1:0]    i_host_write_data,
    output logic [HOSTS-1:0]               o_host_response_ready,
    output logic [DATA_WIDTH-1:0]          o_host_read_data,
    output logic [1:0]                     o_host_status,
    output logic                           o_command_valid,
    output logic                           o_read,
    output logic [ADDRESS_WIDTH-1:0]       o_address,
    output logic [DATA_WIDTH-1:0]          o_write_data,
    input  logic                           i_response_ready,
    input  logic [DATA_WIDTH-1:0]          i_read_data,
    input  logic [1:0]                     i_status
);

    localparam int unsigned GW = (HOSTS > 1) ? $clog2(HOSTS) : 1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] pick;
    logic          found;
    logic          resp_fire;

    // First pass covers hosts at or above the pointer, second pass wraps to host 0.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        for (int h = 0; h < int'(HOSTS); h++) begin
            if (!found && i_host_command_valid[h] && (h >= int'(ptr_q))) begin
                pick  = h[GW-1:0];
                found = 1'b1;
            end
        end
        for (int h = 0; h < int'(HOSTS); h++) begin
            if (!found && i_host_command_valid[h]) begin
                pick  = h[GW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (|i_host_command_valid) begin
                    state_d = StBusy;
                    grant_d = pick;
                    ptr_d   = (int'(pick) == int'(HOSTS) - 1) ? '0 : pick + 1'b1;
                end
            end
            StBusy: begin
                if (i_response_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_command_valid = (state_q == StBusy);
    assign resp_fire       = (state_q == StBusy) && i_response_ready;

    always_comb begin
        o_read                = 1'b0;
        o_address             = '0;
        o_write_data          = '0;
        o_host_response_ready = '0;
        for (int h = 0; h < int'(HOSTS); h++) begin
            if (grant_q == h[GW-1:0]) begin
                o_read                   = i_host_read[h];
                o_address                = i_host_address[h*ADDRESS_WIDTH+:ADDRESS_WIDTH];
                o_write_data             = i_host_write_data[h*DATA_WIDTH+:DATA_WIDTH];
                o_host_response_ready[h] = resp_fire;
            end
        end
    end

    assign o_host_read_data = resp_fire ? i_read_data : '0;
    assign o_host_status    = resp_fire ? i_status : 2'b00;

endmodule

// File: tb/tb_rggen_host_arbiter.sv
// Directed bench for rggen_host_arbiter: a 2-host instance for the main scenarios and a
// 3-host instance for round-robin ordering.
module tb_rggen_host_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] rdata;
    logic [1:0]  status;

    logic [1:0]  v2, rd2, hr2, hst2;
    logic [31:0] addr2, hrd2, dwd2;
    logic [63:0] wd2;
    logic        resp2, cv2, drd2;
    logic [15:0] daddr2;

    logic [2:0]  v3, rd3, hr3;
    logic [47:0] addr3;
    logic [95:0] wd3;
    logic [31:0] hrd3, dwd3;
    logic [1:0]  hst3;
    logic        resp3, cv3, drd3;
    logic [15:0] daddr3;

    int n_cmp = 0;
    int n_err = 0;

    rggen_host_arbiter #(.HOSTS(2), .ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_host_command_valid(v2), .i_host_read(rd2),
        .i_host_address(addr2), .i_host_write_data(wd2),
        .o_host_response_ready(hr2), .o_host_read_data(hrd2), .o_host_status(hst2),
        .o_command_valid(cv2), .o_read(drd2), .o_address(daddr2), .o_write_data(dwd2),
        .i_response_ready(resp2), .i_read_data(rdata), .i_status(status)
    );

    rggen_host_arbiter #(.HOSTS(3), .ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_host_command_valid(v3), .i_host_read(rd3),
        .i_host_address(addr3), .i_host_write_data(wd3),
        .o_host_response_ready(hr3), .o_host_read_data(hrd3), .o_host_status(hst3),
        .o_command_valid(cv3), .o_read(drd3), .o_address(daddr3), .o_write_data(dwd3),
        .i_response_ready(resp3), .i_read_data(rdata), .i_status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        v2 = '0; rd2 = '0; addr2 = '0; wd2 = '0; resp2 = 1'b0;
        v3 = '0; rd3 = '0; addr3 = '0; wd3 = '0; resp3 = 1'b0;
        rdata = '0; status = '0;
        step(); step();
        #1;
        chk("rst_cmd_valid", 64'(cv2), 64'd0);
        chk("rst_host_ready", 64'(hr2), 64'd0);
        chk("rst_read_data", 64'(hrd2), 64'd0);
        chk("rst_status", 64'(hst2), 64'd0);
        rst_n = 1'b1;

        // 1) host0 read of 0x10
        step();
        v2 = 2'b01; rd2 = 2'b01; addr2 = 32'h0000_0010;
        #1 chk("t1_cv_before", 64'(cv2), 64'd0);
        step();
        #1;
        chk("t1_cv_n1", 64'(cv2), 64'd1);
        chk("t1_read", 64'(drd2), 64'd1);
        chk("t1_addr", 64'(daddr2), 64'h10);
        chk("t1_hr_early", 64'(hr2), 64'd0);
        step();
        resp2 = 1'b1; rdata = 32'hCAFE_0001; status = 2'b00;
        #1;
        chk("t1_cv_n2", 64'(cv2), 64'd1);
        chk("t1_hr", 64'(hr2), 64'b01);
        chk("t1_rdata", 64'(hrd2), 64'hCAFE_0001);
        chk("t1_status", 64'(hst2), 64'd0);
        step();
        v2 = 2'b00; resp2 = 1'b0;
        #1;
        chk("t1_cv_n3", 64'(cv2), 64'd0);
        chk("t1_hr_after", 64'(hr2), 64'd0);
        chk("t1_rdata_gated", 64'(hrd2), 64'd0);

        // 6) stray response while idle
        step();
        resp2 = 1'b1; rdata = 32'hDEAD_BEEF; status = 2'b11;
        #1;
        chk("t6_hr", 64'(hr2), 64'd0);
        chk("t6_rdata", 64'(hrd2), 64'd0);
        chk("t6_status", 64'(hst2), 64'd0);
        step();
        resp2 = 1'b0;
        #1 chk("t6_cv", 64'(cv2), 64'd0);

        // 2) both hosts at once after reset: host0 then host1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        v2 = 2'b11; rd2 = 2'b00; addr2 = {16'h0030, 16'h0020};
        wd2 = {32'h1111_1111, 32'h0000_0000};
        step();
        #1;
        chk("t2_cv_a", 64'(cv2), 64'd1);
        chk("t2_addr_a", 64'(daddr2), 64'h20);
        step();
        resp2 = 1'b1; rdata = '0; status = 2'b00;
        #1 chk("t2_hr_a", 64'(hr2), 64'b01);
        step();
        v2 = 2'b10; resp2 = 1'b0;
        #1;
        chk("t2_cv_gap", 64'(cv2), 64'd0);
        chk("t2_hr_gap", 64'(hr2), 64'd0);
        step();
        #1;
        chk("t2_cv_b", 64'(cv2), 64'd1);
        chk("t2_addr_b", 64'(daddr2), 64'h30);
        chk("t2_wdata_b", 64'(dwd2), 64'h1111_1111);
        step();
        resp2 = 1'b1;
        #1 chk("t2_hr_b", 64'(hr2), 64'b10);
        step();
        v2 = 2'b00; resp2 = 1'b0;

        // 4) host1 write to unmapped address, slave error
        step();
        v2 = 2'b10; rd2 = 2'b00; addr2 = {16'hFFF0, 16'h0000};
        wd2 = {32'h0000_5A5A, 32'h0000_0000};
        step();
        #1;
        chk("t4_cv", 64'(cv2), 64'd1);
        chk("t4_read", 64'(drd2), 64'd0);
        chk("t4_addr", 64'(daddr2), 64'hFFF0);
        chk("t4_wdata", 64'(dwd2), 64'h5A5A);
        step();
        resp2 = 1'b1; rdata = '0; status = 2'b01;
        #1;
        chk("t4_hr", 64'(hr2), 64'b10);
        chk("t4_status", 64'(hst2), 64'b01);
        chk("t4_rdata", 64'(hrd2), 64'd0);
        step();
        v2 = 2'b00; resp2 = 1'b0; status = 2'b00;

        // 5) reset while busy, then re-grant of the still-pending host
        step();
        v2 = 2'b01; rd2 = 2'b01; addr2 = {16'h0000, 16'h0044};
        step();
        #1 chk("t5_cv_busy", 64'(cv2), 64'd1);
        #1 rst_n = 1'b0;
        resp2 = 1'b1;
        #1;
        chk("t5_cv_rst", 64'(cv2), 64'd0);
        chk("t5_hr_rst", 64'(hr2), 64'd0);
        step();
        resp2 = 1'b0; rst_n = 1'b1;
        #1 chk("t5_cv_release", 64'(cv2), 64'd0);
        step();
        #1;
        chk("t5_cv_regrant", 64'(cv2), 64'd1);
        chk("t5_addr_regrant", 64'(daddr2), 64'h44);
        step();
        resp2 = 1'b1; rdata = 32'h0000_0044;
        #1;
        chk("t5_hr", 64'(hr2), 64'b01);
        chk("t5_rdata", 64'(hrd2), 64'h44);
        step();
        v2 = 2'b00; resp2 = 1'b0;

        // 3) three hosts continuously requesting: 0,1,2,0,1,2,0,1,2
        step();
        v3 = 3'b111; addr3 = {16'h0102, 16'h0101, 16'h0100}; rd3 = 3'b111;
        step();
        for (int k = 0; k < 9; k++) begin
            #1;
            chk($sformatf("t3_cv_%0d", k), 64'(cv3), 64'd1);
            chk($sformatf("t3_addr_%0d", k), 64'(daddr3), 64'h100 + 64'(k % 3));
            resp3 = 1'b1;
            #1 chk($sformatf("t3_hr_%0d", k), 64'(hr3), 64'd1 << (k % 3));
            step();
            resp3 = 1'b0;
            #1 chk($sformatf("t3_idle_%0d", k), 64'(cv3), 64'd0);
            step();
        end
        v3 = '0;
        chk("t3_dut2_quiet", 64'(cv2), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
